// File: rtl/load_store_unit.sv
// RV32I data-memory access stage: formats stores, drives a req/ack bus, stalls the pipeline
// until completion, and returns aligned sign/zero-extended load data to the writeback mux.
module load_store_unit #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        mem_req_in,
   input  logic        mem_we_in,
   input  logic [2:0]  funct3_in,
   input  logic [31:0] addr_in,
   input  logic [31:0] rs2_in,
   input  logic        flush_in,
   output logic        dmem_req_out,
   output logic        dmem_we_out,
   output logic [31:0] dmem_addr_out,
   output logic [31:0] dmem_wdata_out,
   output logic [3:0]  dmem_wmask_out,
   input  logic        dmem_ack_in,
   input  logic [31:0] dmem_rdata_in,
   output logic        stall_out,
   output logic [31:0] lu_output_out,
   output logic        lu_valid_out,
   output logic        misaligned_out,
   output logic        bus_err_out
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [2:0]        f3_q, f3_d;
   logic [1:0]        lane_q, lane_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        wmask_q, wmask_d;
   logic              discard_q, discard_d;
   logic [31:0]       lu_out_q, lu_out_d;
   logic              lu_vld_q, lu_vld_d;
   logic              mis_q, mis_d;
   logic              err_q, err_d;
   logic              stall_c;
   logic              accept;
   logic              abort;
   logic              discard_now;

   // Loads use funct3[1:0] for size; stores treat anything other than SB/SH as SW.
   function automatic logic is_misaligned(input logic we, input logic [2:0] f3, input logic [1:0] a);
      logic r;
      if (we) begin
         if (f3 == 3'b000)      r = 1'b0;
         else if (f3 == 3'b001) r = a[0];
         else                   r = (a != 2'b00);
      end else begin
         if (f3[1:0] == 2'b00)      r = 1'b0;
         else if (f3[1:0] == 2'b01) r = a[0];
         else                       r = (a != 2'b00);
      end
      return r;
   endfunction

   function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] a);
      logic [3:0] m;
      if (f3 == 3'b000)      m = 4'b0001 << a;
      else if (f3 == 3'b001) m = 4'b0011 << {a[1], 1'b0};
      else                   m = 4'b1111;
      return m;
   endfunction

   function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
      logic [31:0] w;
      if (f3 == 3'b000)      w = {4{d[7:0]}};
      else if (f3 == 3'b001) w = {2{d[15:0]}};
      else                   w = d;
      return w;
   endfunction

   function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] rd);
      logic [31:0] sh;
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      sh = rd >> {a, 3'b000};
      b  = sh[7:0];
      h  = a[1] ? rd[31:16] : rd[15:0];
      case (f3[1:0])
         2'b00:   r = f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
         2'b01:   r = f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
         default: r = rd;
      endcase
      return r;
   endfunction

   assign accept      = mem_req_in & ~flush_in;
   assign abort       = TO_EN && (cnt_q == TO_LAST);
   assign discard_now = discard_q | flush_in;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      we_d      = we_q;
      f3_d      = f3_q;
      lane_d    = lane_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wmask_d   = wmask_q;
      discard_d = discard_q;
      lu_out_d  = lu_out_q;
      lu_vld_d  = 1'b0;
      mis_d     = 1'b0;
      err_d     = 1'b0;
      stall_c   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (is_misaligned(mem_we_in, funct3_in, addr_in[1:0])) begin
                  mis_d = 1'b1;
               end else begin
                  state_d   = BUSY;
                  cnt_d     = '0;
                  we_d      = mem_we_in;
                  f3_d      = funct3_in;
                  lane_d    = addr_in[1:0];
                  addr_d    = {addr_in[31:2], 2'b00};
                  wdata_d   = store_data(funct3_in, rs2_in);
                  wmask_d   = mem_we_in ? store_mask(funct3_in, addr_in[1:0]) : 4'b0000;
                  discard_d = 1'b0;
                  stall_c   = 1'b1;
               end
            end
         end
         BUSY: begin
            // Ack takes priority over a coincident timeout.
            if (dmem_ack_in) begin
               state_d   = IDLE;
               cnt_d     = '0;
               discard_d = 1'b0;
               if (!we_q && !discard_now) begin
                  lu_out_d = load_extract(f3_q, lane_q, dmem_rdata_in);
                  lu_vld_d = 1'b1;
               end
            end else if (abort) begin
               state_d   = IDLE;
               cnt_d     = '0;
               discard_d = 1'b0;
               err_d     = 1'b1;
            end else begin
               cnt_d     = cnt_q + 1'b1;
               discard_d = discard_now;
               stall_c   = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         we_q      <= 1'b0;
         f3_q      <= 3'b000;
         lane_q    <= 2'b00;
         addr_q    <= 32'd0;
         wdata_q   <= 32'd0;
         wmask_q   <= 4'b0000;
         discard_q <= 1'b0;
         lu_out_q  <= 32'd0;
         lu_vld_q  <= 1'b0;
         mis_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         we_q      <= we_d;
         f3_q      <= f3_d;
         lane_q    <= lane_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wmask_q   <= wmask_d;
         discard_q <= discard_d;
         lu_out_q  <= lu_out_d;
         lu_vld_q  <= lu_vld_d;
         mis_q     <= mis_d;
         err_q     <= err_d;
      end
   end

   assign dmem_req_out   = (state_q == BUSY);
   assign dmem_we_out    = we_q;
   assign dmem_addr_out  = addr_q;
   assign dmem_wdata_out = wdata_q;
   assign dmem_wmask_out = wmask_q;
   assign stall_out      = stall_c & rst_n_in;
   assign lu_output_out  = lu_out_q;
   assign lu_valid_out   = lu_vld_q;
   assign misaligned_out = mis_q;
   assign bus_err_out    = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: inputs change 1 time unit after the rising edge,
// outputs are compared on the falling edge.
module tb_load_store_unit;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic        mem_req_in;
   logic        mem_we_in;
   logic [2:0]  funct3_in;
   logic [31:0] addr_in;
   logic [31:0] rs2_in;
   logic        flush_in;
   logic        dmem_req_out;
   logic        dmem_we_out;
   logic [31:0] dmem_addr_out;
   logic [31:0] dmem_wdata_out;
   logic [3:0]  dmem_wmask_out;
   logic        dmem_ack_in;
   logic [31:0] dmem_rdata_in;
   logic        stall_out;
   logic [31:0] lu_output_out;
   logic        lu_valid_out;
   logic        misaligned_out;
   logic        bus_err_out;

   int n_chk = 0;
   int n_err = 0;

   load_store_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
      .clk_in        (clk_in),
      .rst_n_in      (rst_n_in),
      .mem_req_in    (mem_req_in),
      .mem_we_in     (mem_we_in),
      .funct3_in     (funct3_in),
      .addr_in       (addr_in),
      .rs2_in        (rs2_in),
      .flush_in      (flush_in),
      .dmem_req_out  (dmem_req_out),
      .dmem_we_out   (dmem_we_out),
      .dmem_addr_out (dmem_addr_out),
      .dmem_wdata_out(dmem_wdata_out),
      .dmem_wmask_out(dmem_wmask_out),
      .dmem_ack_in   (dmem_ack_in),
      .dmem_rdata_in (dmem_rdata_in),
      .stall_out     (stall_out),
      .lu_output_out (lu_output_out),
      .lu_valid_out  (lu_valid_out),
      .misaligned_out(misaligned_out),
      .bus_err_out   (bus_err_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic cyc;
      @(posedge clk_in);
      #1;
   endtask

   task automatic mid;
      @(negedge clk_in);
   endtask

   task automatic req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
      mem_req_in = 1'b1;
      mem_we_in  = we;
      funct3_in  = f3;
      addr_in    = a;
      rs2_in     = d;
   endtask

   task automatic idle_in;
      mem_req_in    = 1'b0;
      mem_we_in     = 1'b0;
      funct3_in     = 3'b000;
      addr_in       = 32'd0;
      rs2_in        = 32'd0;
      dmem_ack_in   = 1'b0;
      dmem_rdata_in = 32'd0;
      flush_in      = 1'b0;
   endtask

   initial begin
      rst_n_in = 1'b0;
      idle_in();
      mid();
      chk("rst_req", {31'd0, dmem_req_out}, 32'd0);
      chk("rst_stall", {31'd0, stall_out}, 32'd0);
      chk("rst_luout", lu_output_out, 32'd0);
      chk("rst_wmask", {28'd0, dmem_wmask_out}, 32'd0);
      cyc();
      rst_n_in = 1'b1;

      // LB at 0x103, ack in the third request cycle
      req(1'b0, 3'b000, 32'h0000_0103, 32'd0);
      mid();
      chk("t1_stall_acc", {31'd0, stall_out}, 32'd1);
      cyc();
      idle_in();
      mid();
      chk("t1_req", {31'd0, dmem_req_out}, 32'd1);
      chk("t1_addr", dmem_addr_out, 32'h0000_0100);
      chk("t1_wmask", {28'd0, dmem_wmask_out}, 32'd0);
      chk("t1_stall_b1", {31'd0, stall_out}, 32'd1);
      cyc();
      mid();
      chk("t1_stall_b2", {31'd0, stall_out}, 32'd1);
      cyc();
      dmem_ack_in   = 1'b1;
      dmem_rdata_in = 32'h80FF_1234;
      mid();
      chk("t1_stall_ack", {31'd0, stall_out}, 32'd0);
      cyc();
      idle_in();
      mid();
      chk("t1_valid", {31'd0, lu_valid_out}, 32'd1);
      chk("t1_luout", lu_output_out, 32'hFFFF_FF80);
      chk("t1_req_done", {31'd0, dmem_req_out}, 32'd0);
      cyc();
      mid();
      chk("t1_valid_pulse", {31'd0, lu_valid_out}, 32'd0);

      // SH at 0x202
      cyc();
      req(1'b1, 3'b001, 32'h0000_0202, 32'hDEAD_BEEF);
      mid();
      chk("t2_stall_acc", {31'd0, stall_out}, 32'd1);
      cyc();
      idle_in();
      dmem_ack_in = 1'b1;
      mid();
      chk("t2_req", {31'd0, dmem_req_out}, 32'd1);
      chk("t2_we", {31'd0, dmem_we_out}, 32'd1);
      chk("t2_addr", dmem_addr_out, 32'h0000_0200);
      chk("t2_wdata", dmem_wdata_out, 32'hBEEF_BEEF);
      chk("t2_wmask", {28'd0, dmem_wmask_out}, 32'h0000_000C);
      chk("t2_stall_ack", {31'd0, stall_out}, 32'd0);
      cyc();
      idle_in();
      mid();
      chk("t2_novalid", {31'd0, lu_valid_out}, 32'd0);
      chk("t2_req_done", {31'd0, dmem_req_out}, 32'd0);
      chk("t2_luout_hold", lu_output_out, 32'hFFFF_FF80);

      // Misaligned LW at 0x301
      cyc();
      req(1'b0, 3'b010, 32'h0000_0301, 32'd0);
      mid();
      chk("t3_stall", {31'd0, stall_out}, 32'd0);
      cyc();
      idle_in();
      mid();
      chk("t3_mis", {31'd0, misaligned_out}, 32'd1);
      chk("t3_req", {31'd0, dmem_req_out}, 32'd0);
      cyc();
      mid();
      chk("t3_mis_pulse", {31'd0, misaligned_out}, 32'd0);

      // Flushed request in IDLE is ignored entirely
      cyc();
      req(1'b0, 3'b010, 32'h0000_0301, 32'd0);
      flush_in = 1'b1;
      mid();
      chk("t3f_stall", {31'd0, stall_out}, 32'd0);
      cyc();
      idle_in();
      mid();
      chk("t3f_mis", {31'd0, misaligned_out}, 32'd0);
      chk("t3f_req", {31'd0, dmem_req_out}, 32'd0);

      // LHU at 0x402 with no ack: timeout after 4 request cycles
      cyc();
      req(1'b0, 3'b101, 32'h0000_0402, 32'd0);
      cyc();
      idle_in();
      for (int i = 0; i < 4; i++) begin
         mid();
         chk($sformatf("t4_req_c%0d", i + 1), {31'd0, dmem_req_out}, 32'd1);
         chk($sformatf("t4_stall_c%0d", i + 1), {31'd0, stall_out}, (i == 3) ? 32'd0 : 32'd1);
         cyc();
      end
      mid();
      chk("t4_buserr", {31'd0, bus_err_out}, 32'd1);
      chk("t4_req_off", {31'd0, dmem_req_out}, 32'd0);
      chk("t4_luout_hold", lu_output_out, 32'hFFFF_FF80);
      chk("t4_novalid", {31'd0, lu_valid_out}, 32'd0);
      cyc();
      mid();
      chk("t4_buserr_pulse", {31'd0, bus_err_out}, 32'd0);

      // Same LHU with ack in request cycle 4: ack wins
      cyc();
      req(1'b0, 3'b101, 32'h0000_0402, 32'd0);
      cyc();
      idle_in();
      cyc();
      cyc();
      cyc();
      dmem_ack_in   = 1'b1;
      dmem_rdata_in = 32'h8765_4321;
      mid();
      chk("t4b_req_c4", {31'd0, dmem_req_out}, 32'd1);
      cyc();
      idle_in();
      mid();
      chk("t4b_valid", {31'd0, lu_valid_out}, 32'd1);
      chk("t4b_luout", lu_output_out, 32'h0000_8765);
      chk("t4b_nobuserr", {31'd0, bus_err_out}, 32'd0);

      // LBU flushed while BUSY: result discarded
      cyc();
      req(1'b0, 3'b100, 32'h0000_0500, 32'd0);
      cyc();
      idle_in();
      flush_in = 1'b1;
      mid();
      chk("t5_req_flush", {31'd0, dmem_req_out}, 32'd1);
      cyc();
      flush_in      = 1'b0;
      dmem_ack_in   = 1'b1;
      dmem_rdata_in = 32'h0000_00AB;
      mid();
      chk("t5_req_held", {31'd0, dmem_req_out}, 32'd1);
      cyc();
      idle_in();
      mid();
      chk("t5_novalid", {31'd0, lu_valid_out}, 32'd0);
      chk("t5_luout_hold", lu_output_out, 32'h0000_8765);
      req(1'b0, 3'b010, 32'h0000_0600, 32'd0);
      mid();
      chk("t5_next_stall", {31'd0, stall_out}, 32'd1);
      cyc();
      idle_in();
      dmem_ack_in   = 1'b1;
      dmem_rdata_in = 32'h1234_5678;
      mid();
      chk("t5_next_addr", dmem_addr_out, 32'h0000_0600);
      cyc();
      idle_in();
      mid();
      chk("t5_next_valid", {31'd0, lu_valid_out}, 32'd1);
      chk("t5_next_luout", lu_output_out, 32'h1234_5678);

      // Reset asserted mid-BUSY, then a stray ack in IDLE
      cyc();
      req(1'b1, 3'b010, 32'h0000_0700, 32'hCAFE_F00D);
      cyc();
      idle_in();
      mid();
      chk("t6_req_busy", {31'd0, dmem_req_out}, 32'd1);
      #1;
      rst_n_in = 1'b0;
      #1;
      chk("t6_req_rst", {31'd0, dmem_req_out}, 32'd0);
      chk("t6_stall_rst", {31'd0, stall_out}, 32'd0);
      chk("t6_we_rst", {31'd0, dmem_we_out}, 32'd0);
      chk("t6_addr_rst", dmem_addr_out, 32'd0);
      chk("t6_wdata_rst", dmem_wdata_out, 32'd0);
      chk("t6_luout_rst", lu_output_out, 32'd0);
      cyc();
      rst_n_in      = 1'b1;
      dmem_ack_in   = 1'b1;
      dmem_rdata_in = 32'hFFFF_FFFF;
      mid();
      chk("t6_stall_idle", {31'd0, stall_out}, 32'd0);
      cyc();
      idle_in();
      mid();
      chk("t6_novalid", {31'd0, lu_valid_out}, 32'd0);
      chk("t6_luout", lu_output_out, 32'd0);
      chk("t6_req", {31'd0, dmem_req_out}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Data-memory access stage of the RV32I pipeline, directly upstream of the writeback mux select unit.
- Takes load/store requests from the execute stage, with the address taken from the immediate adder output.
- Drives a request/acknowledge data bus, stalls the pipeline until the access completes, and produces the aligned, sign/zero-extended load result that feeds the writeback mux as its load-unit data input.

Parameters:
TIMEOUT_CYCLES, 255, BUSY cycles without ack before abort; 0 disables the timeout
CNT_W, 8, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk_in  input  1  clock, rising edge
rst_n_in  input  1  asynchronous active-low reset
mem_req_in  input  1  execute-stage memory instruction present
mem_we_in  input  1  1 = store, 0 = load
funct3_in  input  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
addr_in  input  32  effective byte address (iadder output)
rs2_in  input  32  store data
flush_in  input  1  pipeline flush
dmem_req_out  output  1  bus request, held until ack
dmem_we_out  output  1  bus write enable
dmem_addr_out  output  32  word-aligned address, {addr[31:2],2'b00}
dmem_wdata_out  output  32  lane-replicated store data
dmem_wmask_out  output  4  byte write mask
dmem_ack_in  input  1  bus completion, single-cycle pulse
dmem_rdata_in  input  32  read data, valid with ack
stall_out  output  1  freeze upstream stages
lu_output_out  output  32  aligned load result
lu_valid_out  output  1  load result valid, one-cycle pulse
misaligned_out  output  1  misaligned access exception, one-cycle pulse
bus_err_out  output  1  timeout abort, one-cycle pulse

Behaviour:
- Reset (async, rst_n_in=0):
  - state=IDLE, counter=0.
  - All outputs and registered bus fields = 0, including lu_output_out.
  - Takes effect immediately, mid-transaction included; dmem_req_out drops at once.
- FSM has two states, IDLE and BUSY.
- IDLE, accept = mem_req_in & ~flush_in:
  - LH/LHU/SH with addr_in[0]=1, or LW/SW with addr_in[1:0]!=0: misaligned_out=1 for one cycle next clock. No bus request. Stay IDLE. stall_out=0.
  - Otherwise capture we, funct3, addr[1:0], bus address, wdata and wmask; go to BUSY.
  - stall_out=1 combinationally in the accept cycle.
- Funct3 decode:
  - Load funct3 011/110/111 is treated as LW.
  - Store funct3 with [1:0]=11 or [2]=1 is treated as SW.
- Store formatting, lane = addr[1:0]:
  - SB: wmask = 0001<<lane, wdata = {4{rs2[7:0]}}.
  - SH: wmask = 0011<<(2*addr[1]), wdata = {2{rs2[15:0]}}.
  - SW: wmask = 1111, wdata = rs2.
  - Loads: wmask = 0000.
- BUSY:
  - dmem_req_out=1 with all bus fields held stable.
  - Counter increments each cycle without ack.
  - stall_out = ~dmem_ack_in & ~abort, so the stall drops in the completion cycle and upstream advances exactly once.
  - On ack:
    - Go to IDLE, counter=0.
    - For a load, register the extracted data into lu_output_out and pulse lu_valid_out the next cycle.
    - Stores produce no lu_valid_out.
  - Abort when TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 without ack:
    - Go to IDLE, pulse bus_err_out.
    - lu_output_out unchanged, no lu_valid_out.
  - Ack in the same cycle as timeout: ack wins, no bus_err_out.
- Load extraction from dmem_rdata_in:
  - LB: sign-extend byte [8*lane+7:8*lane].
  - LBU: zero-extend the same byte.
  - LH: sign-extend half [16*addr[1]+15:16*addr[1]].
  - LHU: zero-extend the same half.
  - LW: full word.
- flush_in during BUSY:
  - The bus transaction completes; it is never cancelled on the bus.
  - A sticky discard flag suppresses lu_valid_out; lu_output_out is not updated.
  - The flag clears on return to IDLE.
- flush_in in IDLE: the request is ignored, with no misaligned_out.
- dmem_ack_in while IDLE is ignored.
- lu_output_out holds its last value between loads.
- Back-to-back: a new request is accepted in the first IDLE cycle after completion, giving a minimum 2 cycles per access with ack one cycle after request.

Test Plan:
1. LB at addr 0x103, rdata 0x80FF_1234, ack 2 cycles after req -> dmem_addr_out=0x100, wmask=0000, lu_output_out=0xFFFF_FF80, lu_valid_out one pulse, stall_out high from accept to the cycle before ack.
2. SH at addr 0x202, rs2 0xDEAD_BEEF -> wdata=0xBEEF_BEEF, wmask=1100, we=1, no lu_valid_out, stall drops in the ack cycle.
3. LW at addr 0x301 -> misaligned_out single pulse, dmem_req_out stays 0, stall_out=0.
4. LHU at addr 0x402 with TIMEOUT_CYCLES=4 and no ack -> req held exactly 4 cycles, then bus_err_out pulse, req=0, lu_output_out unchanged. Repeat with ack in cycle 4 -> valid result, no bus_err_out.
5. LBU issued, flush_in asserted in BUSY, ack rdata 0x0000_00AB -> lu_valid_out never pulses, lu_output_out keeps its old value, next request accepted normally.
6. rst_n_in pulsed low mid-BUSY -> all outputs 0 immediately, state IDLE, a later ack is ignored.
